// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_engine
// Brief    : UART receive engine: mid-bit sampling, 7/8 data bits, optional
//            odd/even parity, one stop bit, sticky status until cleared.
// Revision : 1.0
// ============================================================================
module uart_rx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic [18:0] k,
    input  logic        clear,
    output logic        rxrdy,
    output logic [7:0]  rdata,
    output logic        pe,
    output logic        fe,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [18:0] r_btc;
    logic [3:0]  r_bc;
    logic [9:0]  r_sh;
    logic        r_rxrdy;
    logic [7:0]  r_rdata;
    logic        r_pe;
    logic        r_fe;
    logic        r_ovf;

    logic        w_rxs;
    logic [3:0]  w_nbits;
    logic [3:0]  w_shamt;
    logic [9:0]  w_al;
    logic [3:0]  w_stop_idx;
    logic [3:0]  w_par_idx;
    logic [7:0]  w_data;
    logic        w_par_exp;
    logic        w_pe;
    logic        w_fe;

    assign w_rxs = r_sync2;

    // Samples land MSB-first in a 10-bit window; fewer than 10 samples leave
    // the frame high-aligned, so shift it down until data LSB sits in bit 0.
    assign w_nbits    = 4'd9 + {3'b000, eight} + {3'b000, pen};
    assign w_shamt    = 4'd11 - w_nbits;
    assign w_al       = r_sh >> w_shamt;
    assign w_stop_idx = w_nbits - 4'd2;
    assign w_par_idx  = 4'd7 + {3'b000, eight};
    assign w_data     = eight ? w_al[7:0] : {1'b0, w_al[6:0]};
    assign w_par_exp  = ohel ? ~^w_data : ^w_data;
    assign w_pe       = pen & (w_al[w_par_idx] != w_par_exp);
    assign w_fe       = ~w_al[w_stop_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_btc   <= '0;
            r_bc    <= '0;
            r_sh    <= '0;
            r_rxrdy <= 1'b0;
            r_rdata <= '0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (clear && (r_state != S_DONE)) begin
                r_rxrdy <= 1'b0;
                r_pe    <= 1'b0;
                r_fe    <= 1'b0;
                r_ovf   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_btc <= '0;
                    r_bc  <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    // Magnitude compare keeps a mid-frame change of k from
                    // stalling the counter.
                    if (r_btc >= {1'b0, k[18:1]}) begin
                        r_btc <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bc    <= 4'd1;
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_btc <= r_btc + 19'd1;
                    end
                end

                S_DATA: begin
                    if (r_btc >= k) begin
                        r_btc <= '0;
                        r_sh  <= {w_rxs, r_sh[9:1]};
                        r_bc  <= r_bc + 4'd1;
                        if ((r_bc + 4'd1) >= w_nbits) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_btc <= r_btc + 19'd1;
                    end
                end

                S_DONE: begin
                    r_rdata <= w_data;
                    r_pe    <= w_pe;
                    r_fe    <= w_fe;
                    r_ovf   <= clear ? 1'b0 : (r_ovf | r_rxrdy);
                    r_rxrdy <= 1'b1;
                    r_btc   <= '0;
                    r_bc    <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rxrdy = r_rxrdy;
    assign rdata = r_rdata;
    assign pe    = r_pe;
    assign fe    = r_fe;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_engine
// Brief    : Directed self-checking bench for uart_rx_engine.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_engine;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [18:0] k;
    logic        clear;
    logic        rxrdy;
    logic [7:0]  rdata;
    logic        pe;
    logic        fe;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_engine dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .eight (eight),
        .pen   (pen),
        .ohel  (ohel),
        .k     (k),
        .clear (clear),
        .rxrdy (rxrdy),
        .rdata (rdata),
        .pe    (pe),
        .fe    (fe),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rdy, input logic [7:0] e_data,
                           input logic e_pe, input logic e_fe, input logic e_ovf);
        chk({tag, "_rxrdy"}, {7'd0, rxrdy}, {7'd0, e_rdy});
        chk({tag, "_rdata"}, rdata, e_data);
        chk({tag, "_pe"},    {7'd0, pe},    {7'd0, e_pe});
        chk({tag, "_fe"},    {7'd0, fe},    {7'd0, e_fe});
        chk({tag, "_ovf"},   {7'd0, ovf},   {7'd0, e_ovf});
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Bit period is 10 clocks (k=9). clr_edge/rst_edge number the clock edges
    // from 1 starting right after the start bit is driven; 0 means never.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                              input int clr_edge, input int rst_edge);
        logic [10:0] bits;
        int          n;
        int          e;
        bit          abort;
        bits    = '0;
        n       = 1;
        for (int i = 0; i < (eight ? 8 : 7); i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pen) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = stopb;
        n++;
        e     = 0;
        abort = 0;
        for (int b = 0; b < n && !abort; b++) begin
            rx = bits[b];
            for (int c = 0; c < 10 && !abort; c++) begin
                e++;
                clear = (e == clr_edge);
                reset = (e == rst_edge);
                @(posedge clk);
                #1;
                if (reset) abort = 1;
            end
        end
        rx    = 1'b1;
        clear = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        clear = 1'b0;
        k     = 19'd9;
        eight = 1'b1;
        pen   = 1'b1;
        ohel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(5);

        // 8E1, good parity
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        chk_all("a5_even_ok", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        chk_all("a5_cleared", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        chk_all("a5_even_bad", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        pulse_clear();
        idle(5);

        ohel = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        chk_all("a5_odd_ok", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        idle(5);

        // 7N1
        eight = 1'b0;
        pen   = 1'b0;
        ohel  = 1'b0;
        send_frame(8'hC1, 1'b0, 1'b1, 0, 0);
        chk_all("41_7bit", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        idle(5);

        send_frame(8'h41, 1'b0, 1'b0, 0, 0);
        chk_all("41_framing", 1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        idle(25);
        pulse_clear();
        idle(5);

        // Back-to-back 8E1 frames, overrun, then clear coinciding with DONE
        eight = 1'b1;
        pen   = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
        chk("b2b_first_ovf", {7'd0, ovf}, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
        chk_all("b2b_overrun", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 109, 0);
        chk_all("clear_at_done", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        idle(5);

        // Glitch shorter than half a bit is rejected
        rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(20);
        chk_all("false_start", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 0, 0);
        chk_all("after_glitch", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Reset in the middle of the 4th data bit
        send_frame(8'h5A, 1'b0, 1'b1, 0, 45);
        chk_all("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(20);
        send_frame(8'hF0, 1'b0, 1'b1, 0, 0);
        chk_all("after_reset", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
